multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: max cycles to wait for mem_ready before trapping (range 2..255).
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port instr, input, 32: current instruction from the IR; opcode=instr[6:0].
REQ-005 SHALL have port mem_ready, input, 1: memory completes the pending access this cycle.
REQ-006 SHALL have port branch_taken, input, 1: comparator result for the current branch.
REQ-007 SHALL have outputs pc_we, ir_we, rf_we, mem_req, mem_we, mem_addr_sel, is_branch, is_jalr, each 1 bit: datapath strobes and selects (mem_addr_sel 0=PC, 1=ALU result).
REQ-008 SHALL have outputs alu_src_a and alu_src_b, 2 bits each: a is 0=rs1, 1=PC, 2=zero; b is 0=rs2, 1=imm, 2=const 4.
REQ-009 SHALL have outputs pc_src and wb_sel, 2 bits each: pc_src is 0=PC+4, 1=PC+imm, 2=ALU&~1; wb_sel is 0=ALU, 1=mem data, 2=PC+4.
REQ-010 SHALL have outputs illegal, timeout and retired, 1 bit each; state, 3 bits; retired_count, 32 bits.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; all strobes decode combinationally from state and instr.
REQ-012 FETCH SHALL drive mem_req=1 and mem_addr_sel=0, and hold until mem_ready; on mem_ready it SHALL pulse ir_we=1 that same cycle and go to DECODE.
REQ-013 DECODE SHALL take one cycle; opcodes 0110011, 0010011, 0110111, 0010111, 0000011, 0100011, 1100011, 1101111 and 1100111 go to EXECUTE, and any other opcode goes to TRAP with illegal set.
REQ-014 EXECUTE SHALL set the ALU sources by opcode:
- REG: (0,0).
- IMM, LOAD, STORE, JALR: (0,1).
- LUI: (2,1).
- AUIPC: (1,1).
- BRANCH: (0,0).
- JAL: don't-care, with 0 driven.
REQ-015 EXECUTE SHALL assert is_branch=1 for BRANCH and is_jalr=1 for JALR.
REQ-016 EXECUTE next state SHALL be:
- LOAD/STORE: MEM.
- BRANCH: FETCH, with pc_we=1 and pc_src=branch_taken?1:0.
- All others: WB.
REQ-017 In MEM and WB, alu_src_a/b, is_branch and is_jalr SHALL equal the values driven in EXECUTE for the same instruction.
REQ-018 MEM SHALL drive mem_req=1, mem_addr_sel=1 and mem_we=(STORE), holding until mem_ready.
REQ-019 On mem_ready in MEM, a STORE SHALL go to FETCH with pc_we=1 and pc_src=0, and a LOAD SHALL go to WB.
REQ-020 WB SHALL assert rf_we=1 and pc_we=1 for one cycle, then go to FETCH, with:
- LOAD: wb_sel=1.
- JAL: wb_sel=2, pc_src=1.
- JALR: wb_sel=2, pc_src=2.
- All others: wb_sel=0, pc_src=0.
REQ-021 retired SHALL pulse exactly in the cycle the last pc_we of an instruction is asserted, and retired_count SHALL increment on it, wrapping 0xFFFFFFFF to 0.
REQ-022 A wait counter SHALL clear on entry to FETCH or MEM and count each cycle mem_req=1 with mem_ready=0.
REQ-023 When the wait counter reaches MEM_TIMEOUT-1 while mem_ready=0, the next state SHALL be TRAP with timeout set; mem_ready in that same cycle SHALL win and no trap occurs.
REQ-024 TRAP SHALL be sticky until rst, with all strobes 0; illegal and timeout SHALL stay set while in TRAP.
REQ-025 Only one of pc_we or ir_we SHALL ever be asserted in a cycle; mem_we SHALL never be asserted without mem_req.
REQ-026 Instruction latency with zero memory wait SHALL be:
- BRANCH: 3 cycles.
- REG/IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
- STORE: 4 cycles.
- LOAD: 5 cycles.

Reset
REQ-027 While rst=1, state SHALL load FETCH, retired_count 0, wait counter 0, and illegal and timeout 0; all strobe outputs SHALL be forced 0.
REQ-028 The first cycle after rst deasserts SHALL be FETCH with mem_req=1.
REQ-029 Asserting rst in any state, including mid-MEM or TRAP, SHALL abort the instruction with no further pc_we, rf_we or mem_we.

Verification
REQ-030 ADD x1,x2,x3 (0x003100B3) with mem_ready always 1 -> states 0,1,2,4,0; rf_we=1 and wb_sel=0 in cycle 4; retired_count=1.
REQ-031 LW with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with mem_we=0; WB wb_sel=1; no timeout.
REQ-032 BEQ with branch_taken=1 -> is_branch=1 and pc_we=1 with pc_src=1 in EXECUTE; rf_we never asserted.
REQ-033 instr opcode 0x7F -> DECODE to TRAP, illegal=1; TRAP persists for 20 cycles; rst returns state to 0.
REQ-034 FETCH with mem_ready held 0 and MEM_TIMEOUT=16 -> TRAP entered after 16 cycles, timeout=1; mem_ready on wait cycle 15 -> normal DECODE.
REQ-035 retired_count preloaded to 0xFFFFFFFF by 2^32-1 retirements or a force, then one more retirement -> wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: the instruction/handshake inputs and every
// strobe or mux select the multicycle controller drives.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;

    logic        pc_we;
    logic        ir_we;
    logic        rf_we;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        is_branch;
    logic        is_jalr;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic [1:0]  wb_sel;

    modport master (
        input  instr, mem_ready, branch_taken,
        output pc_we, ir_we, rf_we, mem_req, mem_we, mem_addr_sel,
        output is_branch, is_jalr, alu_src_a, alu_src_b, pc_src, wb_sel
    );

    modport slave (
        output instr, mem_ready, branch_taken,
        input  pc_we, ir_we, rf_we, mem_req, mem_we, mem_addr_sel,
        input  is_branch, is_jalr, alu_src_a, alu_src_b, pc_src, wb_sel
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-style control FSM: FETCH/DECODE/EXECUTE/MEM/WB plus a sticky
// TRAP for illegal opcodes and memory timeouts; counts retired instructions.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus,
    output logic              illegal,
    output logic              timeout,
    output logic              retired,
    output logic [2:0]        state,
    output logic [31:0]       retired_count
);
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg;
    logic [31:0] retired_count_reg;
    logic        illegal_reg, timeout_reg;
    logic        illegal_set, timeout_set;

    logic        pc_we_c, ir_we_c, rf_we_c, mem_req_c, mem_we_c, mem_addr_sel_c;
    logic        is_branch_c, is_jalr_c;
    logic [1:0]  alu_src_a_c, alu_src_b_c, pc_src_c, wb_sel_c;
    logic [1:0]  src_a, src_b;

    logic [6:0]  opcode;
    logic        is_reg, is_imm, is_lui, is_auipc, is_load, is_store;
    logic        is_br, is_jal, is_jr, is_legal, wait_expired;
    logic        unused_instr_bits;

    assign opcode   = bus.instr[6:0];
    assign is_reg   = (opcode == 7'b0110011);
    assign is_imm   = (opcode == 7'b0010011);
    assign is_lui   = (opcode == 7'b0110111);
    assign is_auipc = (opcode == 7'b0010111);
    assign is_load  = (opcode == 7'b0000011);
    assign is_store = (opcode == 7'b0100011);
    assign is_br    = (opcode == 7'b1100011);
    assign is_jal   = (opcode == 7'b1101111);
    assign is_jr    = (opcode == 7'b1100111);
    assign is_legal = is_reg | is_imm | is_lui | is_auipc | is_load | is_store
                    | is_br | is_jal | is_jr;
    assign unused_instr_bits = ^bus.instr[31:7];

    assign wait_expired = (wait_cnt_reg == WAIT_LIMIT);

    // ALU operand selects depend only on the opcode, so EXECUTE, MEM and WB
    // all present the same values for one instruction.
    always_comb begin
        src_a = 2'd0;
        src_b = 2'd0;
        if (is_lui) begin
            src_a = 2'd2;
            src_b = 2'd1;
        end else if (is_auipc) begin
            src_a = 2'd1;
            src_b = 2'd1;
        end else if (is_imm | is_load | is_store | is_jr) begin
            src_b = 2'd1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        illegal_set    = 1'b0;
        timeout_set    = 1'b0;
        pc_we_c        = 1'b0;
        ir_we_c        = 1'b0;
        rf_we_c        = 1'b0;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        is_branch_c    = 1'b0;
        is_jalr_c      = 1'b0;
        alu_src_a_c    = 2'd0;
        alu_src_b_c    = 2'd0;
        pc_src_c       = 2'd0;
        wb_sel_c       = 2'd0;

        case (state_reg)
            FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_we_c    = 1'b1;
                    state_next = DECODE;
                end else if (wait_expired) begin
                    timeout_set = 1'b1;
                    state_next  = TRAP;
                end
            end
            DECODE: begin
                if (is_legal) begin
                    state_next = EXECUTE;
                end else begin
                    illegal_set = 1'b1;
                    state_next  = TRAP;
                end
            end
            EXECUTE: begin
                alu_src_a_c = src_a;
                alu_src_b_c = src_b;
                is_branch_c = is_br;
                is_jalr_c   = is_jr;
                if (is_load | is_store) begin
                    state_next = MEM;
                end else if (is_br) begin
                    pc_we_c    = 1'b1;
                    pc_src_c   = bus.branch_taken ? 2'd1 : 2'd0;
                    state_next = FETCH;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                alu_src_a_c    = src_a;
                alu_src_b_c    = src_b;
                is_branch_c    = is_br;
                is_jalr_c      = is_jr;
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_we_c       = is_store;
                if (bus.mem_ready) begin
                    if (is_store) begin
                        pc_we_c    = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (wait_expired) begin
                    timeout_set = 1'b1;
                    state_next  = TRAP;
                end
            end
            WB: begin
                alu_src_a_c = src_a;
                alu_src_b_c = src_b;
                is_branch_c = is_br;
                is_jalr_c   = is_jr;
                rf_we_c     = 1'b1;
                pc_we_c     = 1'b1;
                state_next  = FETCH;
                if (is_load) begin
                    wb_sel_c = 2'd1;
                end else if (is_jal) begin
                    wb_sel_c = 2'd2;
                    pc_src_c = 2'd1;
                end else if (is_jr) begin
                    wb_sel_c = 2'd2;
                    pc_src_c = 2'd2;
                end
            end
            TRAP: state_next = TRAP;
            default: state_next = FETCH;
        endcase

        // Reset must silence the datapath in the same cycle it is asserted.
        if (rst) begin
            pc_we_c        = 1'b0;
            ir_we_c        = 1'b0;
            rf_we_c        = 1'b0;
            mem_req_c      = 1'b0;
            mem_we_c       = 1'b0;
            mem_addr_sel_c = 1'b0;
            is_branch_c    = 1'b0;
            is_jalr_c      = 1'b0;
            alu_src_a_c    = 2'd0;
            alu_src_b_c    = 2'd0;
            pc_src_c       = 2'd0;
            wb_sel_c       = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= FETCH;
            wait_cnt_reg      <= '0;
            retired_count_reg <= '0;
            illegal_reg       <= 1'b0;
            timeout_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Any state change restarts the wait count; only FETCH/MEM use it.
            if (state_next != state_reg) begin
                wait_cnt_reg <= '0;
            end else if (mem_req_c && !bus.mem_ready) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
            if (illegal_set) illegal_reg <= 1'b1;
            if (timeout_set) timeout_reg <= 1'b1;
            if (pc_we_c)     retired_count_reg <= retired_count_reg + 32'd1;
        end
    end

    // Each instruction writes the PC exactly once, as its final action.
    assign retired       = pc_we_c;
    assign retired_count = retired_count_reg;
    assign illegal       = illegal_reg;
    assign timeout       = timeout_reg;
    assign state         = state_reg;

    assign bus.pc_we        = pc_we_c;
    assign bus.ir_we        = ir_we_c;
    assign bus.rf_we        = rf_we_c;
    assign bus.mem_req      = mem_req_c;
    assign bus.mem_we       = mem_we_c;
    assign bus.mem_addr_sel = mem_addr_sel_c;
    assign bus.is_branch    = is_branch_c;
    assign bus.is_jalr      = is_jalr_c;
    assign bus.alu_src_a    = alu_src_a_c;
    assign bus.alu_src_b    = alu_src_b_c;
    assign bus.pc_src       = pc_src_c;
    assign bus.wb_sel       = wb_sel_c;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: walks each instruction class
// through the FSM and checks strobes, latencies, traps and the retire counter.
module tb_multicycle_ctrl;
    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_ADDI  = 32'h00110093;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_LW    = 32'h00012083;
    localparam logic [31:0] I_SW    = 32'h00112023;
    localparam logic [31:0] I_BEQ   = 32'h00000463;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    logic        clk;
    logic        rst;
    logic        illegal, timeout, retired;
    logic [2:0]  state;
    logic [31:0] retired_count;
    logic [31:0] exp_ret;
    int          vec_count;
    int          miss_count;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .illegal       (illegal),
        .timeout       (timeout),
        .retired       (retired),
        .state         (state),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.branch_taken = 1'b0;
        #1;
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_ir_we", 32'(bus.ir_we), 0);
        tick();
        tick();
        check("rst_state", 32'(state), 0);
        check("rst_count", retired_count, 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("post_rst_mem_req", 32'(bus.mem_req), 1);
        exp_ret = '0;
    endtask

    // Enters in FETCH; leaves in DECODE after 'waits' idle cycles.
    task automatic fetch(input logic [31:0] iw, input int waits);
        bus.instr = iw;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            check("fetch_wait_state", 32'(state), 0);
            check("fetch_wait_ir_we", 32'(bus.ir_we), 0);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        check("fetch_state", 32'(state), 0);
        check("fetch_addr_sel", 32'(bus.mem_addr_sel), 0);
        check("fetch_ir_we", 32'(bus.ir_we), 1);
        check("fetch_pc_we", 32'(bus.pc_we), 0);
        tick();
        check("decode_state", 32'(state), 1);
    endtask

    task automatic run_simple(input string tag, input logic [31:0] iw, input int waits,
                              input logic [1:0] a, input logic [1:0] b, input logic jr,
                              input logic [1:0] wsel, input logic [1:0] psrc);
        fetch(iw, waits);
        tick();
        check({tag, "_ex_state"}, 32'(state), 2);
        check({tag, "_ex_src_a"}, 32'(bus.alu_src_a), 32'(a));
        check({tag, "_ex_src_b"}, 32'(bus.alu_src_b), 32'(b));
        check({tag, "_ex_jalr"}, 32'(bus.is_jalr), 32'(jr));
        check({tag, "_ex_pc_we"}, 32'(bus.pc_we), 0);
        tick();
        check({tag, "_wb_state"}, 32'(state), 4);
        check({tag, "_wb_rf_we"}, 32'(bus.rf_we), 1);
        check({tag, "_wb_pc_we"}, 32'(bus.pc_we), 1);
        check({tag, "_wb_sel"}, 32'(bus.wb_sel), 32'(wsel));
        check({tag, "_wb_pc_src"}, 32'(bus.pc_src), 32'(psrc));
        check({tag, "_wb_src_a"}, 32'(bus.alu_src_a), 32'(a));
        check({tag, "_wb_src_b"}, 32'(bus.alu_src_b), 32'(b));
        check({tag, "_wb_retired"}, 32'(retired), 1);
        exp_ret = exp_ret + 32'd1;
        tick();
        check({tag, "_next_state"}, 32'(state), 0);
        check({tag, "_count"}, retired_count, exp_ret);
        $display("[%0t] %s retired, count=%0d", $time, tag, retired_count);
    endtask

    initial begin
        vec_count = 0;
        miss_count = 0;
        rst = 1'b1;
        bus.instr = I_ADD;
        bus.mem_ready = 1'b0;
        bus.branch_taken = 1'b0;
        exp_ret = '0;
        tick();
        do_reset();

        run_simple("add",   I_ADD,   0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
        run_simple("addi",  I_ADDI,  0, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0);
        run_simple("lui",   I_LUI,   0, 2'd2, 2'd1, 1'b0, 2'd0, 2'd0);
        run_simple("auipc", I_AUIPC, 0, 2'd1, 2'd1, 1'b0, 2'd0, 2'd0);
        run_simple("jal",   I_JAL,   0, 2'd0, 2'd0, 1'b0, 2'd2, 2'd1);
        run_simple("jalr",  I_JALR,  0, 2'd0, 2'd1, 1'b1, 2'd2, 2'd2);

        // LW with three wait cycles in MEM
        fetch(I_LW, 0);
        tick();
        check("lw_ex_src_b", 32'(bus.alu_src_b), 1);
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lw_mem_state", 32'(state), 3);
            check("lw_mem_req", 32'(bus.mem_req), 1);
            check("lw_mem_addr_sel", 32'(bus.mem_addr_sel), 1);
            check("lw_mem_we", 32'(bus.mem_we), 0);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        check("lw_mem_last_state", 32'(state), 3);
        check("lw_mem_pc_we", 32'(bus.pc_we), 0);
        tick();
        check("lw_wb_state", 32'(state), 4);
        check("lw_wb_sel", 32'(bus.wb_sel), 1);
        check("lw_wb_rf_we", 32'(bus.rf_we), 1);
        check("lw_timeout", 32'(timeout), 0);
        exp_ret = exp_ret + 32'd1;
        tick();
        check("lw_count", retired_count, exp_ret);
        $display("[%0t] lw retired, count=%0d", $time, retired_count);

        // SW: retires from MEM, four cycles total
        fetch(I_SW, 0);
        tick();
        tick();
        check("sw_mem_state", 32'(state), 3);
        check("sw_mem_we", 32'(bus.mem_we), 1);
        check("sw_pc_we", 32'(bus.pc_we), 1);
        check("sw_pc_src", 32'(bus.pc_src), 0);
        check("sw_rf_we", 32'(bus.rf_we), 0);
        check("sw_retired", 32'(retired), 1);
        exp_ret = exp_ret + 32'd1;
        tick();
        check("sw_next_state", 32'(state), 0);
        check("sw_count", retired_count, exp_ret);
        $display("[%0t] sw retired, count=%0d", $time, retired_count);

        // BEQ taken then not taken: retires from EXECUTE
        for (int t = 1; t >= 0; t--) begin
            fetch(I_BEQ, 0);
            bus.branch_taken = (t == 1);
            tick();
            check("beq_ex_state", 32'(state), 2);
            check("beq_is_branch", 32'(bus.is_branch), 1);
            check("beq_pc_we", 32'(bus.pc_we), 1);
            check("beq_pc_src", 32'(bus.pc_src), 32'(t));
            check("beq_rf_we", 32'(bus.rf_we), 0);
            exp_ret = exp_ret + 32'd1;
            tick();
            check("beq_next_state", 32'(state), 0);
            check("beq_count", retired_count, exp_ret);
            bus.branch_taken = 1'b0;
            $display("[%0t] beq taken=%0d retired, count=%0d", $time, t, retired_count);
        end

        // mem_ready on the last allowed wait cycle: no trap
        run_simple("add_wait15", I_ADD, 15, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
        check("wait15_timeout", 32'(timeout), 0);

        // FETCH never answered: trap after 16 cycles
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("to_fetch_state", 32'(state), 0);
            tick();
        end
        check("to_trap_state", 32'(state), 5);
        check("to_timeout", 32'(timeout), 1);
        check("to_illegal", 32'(illegal), 0);
        check("to_mem_req", 32'(bus.mem_req), 0);
        $display("[%0t] fetch timeout trap", $time);
        do_reset();

        // Illegal opcode: sticky TRAP
        fetch(I_BAD, 0);
        tick();
        check("ill_trap_state", 32'(state), 5);
        for (int i = 0; i < 20; i++) begin
            check("ill_hold_state", 32'(state), 5);
            check("ill_hold_flag", 32'(illegal), 1);
            check("ill_strobes", 32'({bus.pc_we, bus.ir_we, bus.rf_we, bus.mem_req, bus.mem_we}), 0);
            tick();
        end
        $display("[%0t] illegal opcode trap held 20 cycles", $time);
        do_reset();

        // Reset in the middle of a stalled store
        fetch(I_SW, 0);
        bus.mem_ready = 1'b0;
        tick();
        tick();
        check("mid_mem_state", 32'(state), 3);
        check("mid_mem_we", 32'(bus.mem_we), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_mem_we", 32'(bus.mem_we), 0);
        check("mid_rst_pc_we", 32'(bus.pc_we), 0);
        $display("[%0t] reset during MEM", $time);
        do_reset();

        // Counter wrap
        @(negedge clk);
        force dut.retired_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_reg;
        tick();
        check("wrap_preload", retired_count, 32'hFFFF_FFFF);
        exp_ret = 32'hFFFF_FFFF;
        run_simple("add_wrap", I_ADD, 0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
        check("wrap_zero", retired_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
